dma_desc_sched: RTL and testbench
=================================

// Module: dma_desc_sched
// PURPOSE
//  Sequences the DMA descriptor table onto the rd/wr streamer pair.
//  - Picks the next enabled descriptor round-robin and issues its src/dst/bytes job to both streamers.
//  - Waits for both streamers to finish, then tracks per-descriptor completion.
//  - Handles abort, AXI drain and FIFO clear. Sits between the CSR block and the streamers, in place of ad-hoc sequencing.
// PARAMETERS
//  NUM_DESC     `DMA_NUM_DESC  descriptor slots, >=2
//  ADDR_W       32             address width
//  BYTES_W      32             transfer-length width
//  TIMEOUT_CYC  4096           watchdog limit in WAIT (used only with DMA_SCHED_TIMEOUT_EN)
// PORTS
//  clk          in   1                 clock, all logic rising-edge
//  rst          in   1                 synchronous reset, active-high
//  go_i         in   1                 level start request from CSR
//  abort_i      in   1                 level abort request from CSR
//  desc_en_i    in   NUM_DESC          per-descriptor enable
//  desc_src_i   in   NUM_DESC*ADDR_W   source addresses, slot k at [k*ADDR_W +: ADDR_W]
//  desc_dst_i   in   NUM_DESC*ADDR_W   destination addresses
//  desc_bytes_i in   NUM_DESC*BYTES_W  byte counts
//  rd_valid_o   out  1                 read-job valid
//  rd_ready_i   in   1                 read streamer accepts job
//  rd_addr_o    out  ADDR_W            read job address
//  rd_bytes_o   out  BYTES_W           read job length
//  wr_valid_o   out  1                 write-job valid
//  wr_ready_i   in   1                 write streamer accepts job
//  wr_addr_o    out  ADDR_W            write job address
//  wr_bytes_o   out  BYTES_W           write job length
//  rd_done_i    in   1                 1-cycle pulse: read job complete
//  wr_done_i    in   1                 1-cycle pulse: write job complete
//  pend_txn_i   in   1                 AXI I/F has outstanding txns
//  clear_o      out  1                 1-cycle FIFO/AXI-I/F clear pulse
//  active_o     out  1                 high in any state except IDLE/DONE
//  done_o       out  1                 run finished, held until go_i low
//  cur_desc_o   out  $clog2(NUM_DESC)  descriptor being serviced
//  desc_done_o  out  NUM_DESC          sticky per-descriptor completion
//  err_tmo_o    out  1                 watchdog fired (sticky until next start)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, snapshot mask=0; every output is 0.
//  FSM states: IDLE, SELECT, ISSUE, WAIT, DRAIN, DONE.
//  IDLE
//   - go_i=1 -> SELECT. Snapshot desc_en_i into pend_mask.
//   - Clear desc_done_o and err_tmo_o. Pulse clear_o in that same cycle.
//  SELECT
//   - Scan pend_mask from rr_ptr upward, wrapping; first set bit k is the pick.
//   - bytes[k]!=0: cur_desc_o=k -> ISSUE.
//   - bytes[k]==0: clear pend_mask[k], set desc_done_o[k], stay in SELECT.
//   - pend_mask==0 -> DRAIN.
//  ISSUE
//   - rd_valid_o/wr_valid_o rise together, 1 cycle after the SELECT pick. That is 2 cycles after go_i.
//   - Payloads: rd_addr_o=src[k], wr_addr_o=dst[k], both byte fields=bytes[k]; held stable while valid.
//   - Each valid drops the cycle after its own ready; the two handshakes are independent.
//   - Both accepted -> WAIT.
//  WAIT
//   - rd_done_i and wr_done_i are latched into sticky flags, in either order or same cycle.
//   - Both flags set -> set desc_done_o[k], clear pend_mask[k], rr_ptr=(k+1) mod NUM_DESC -> SELECT.
//   - Done pulses outside WAIT are ignored.
//  DRAIN
//   - Wait for pend_txn_i==0 -> DONE.
//   - Pulse clear_o on exit only if abort or timeout caused the drain.
//  DONE: done_o=1; go_i==0 -> IDLE.
//  Abort
//   - abort_i=1 in SELECT/ISSUE/WAIT -> DRAIN next cycle. Valids drop with the state change.
//   - Current desc_done_o bit is not set; pend_mask is discarded.
//  Precedence: abort_i wins over go_i and done pulses in the same cycle. go_i low mid-run is ignored.
//  rst mid-run: everything returns to reset values the next cycle; no clear_o pulse.
// CONFIGURATION
//  DMA_SCHED_TIMEOUT_EN defined
//   - 16-bit counter runs in WAIT and resets on entry.
//   - Reaching TIMEOUT_CYC sets err_tmo_o -> DRAIN, handled like abort.
//  DMA_SCHED_TIMEOUT_EN undefined: no counter; err_tmo_o tied 0; TIMEOUT_CYC unused.
// TESTING
//  T1 en=2'b11, bytes={64,32}, instant readies, done pulses 5 cycles after accept
//     -> slot0 then slot1 issued; desc_done=2'b11; done_o; clear_o exactly once.
//  T2 rd_ready 3 cycles late, wr_ready immediate -> wr_valid high 1 cycle, rd_valid 4; no second issue.
//  T3 en=2'b11, bytes[0]=0 -> slot0 done without any valid; only slot1 (bytes=32) issued.
//  T4 abort_i in WAIT, pend_txn_i high 10 more cycles
//     -> DRAIN for 10 cycles, clear_o pulse, DONE, desc_done bit clear.
//  T5 wr_done_i before rd_done_i, then same-cycle pair on next slot -> both slots complete correctly.
//  T6 (TIMEOUT_EN, TIMEOUT_CYC=16) rd_done never arrives -> err_tmo_o at cycle 16 of WAIT, DRAIN, DONE.

Source files
------------

// File: rtl/dma_desc_sched_if.sv
// Job handshake between the descriptor scheduler (master) and the rd/wr streamer pair (slave).
// Carries the per-channel job valid/ready/payload and the per-channel completion pulse.
interface dma_desc_sched_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BYTES_W = 32
);
    logic               rd_valid;
    logic               rd_ready;
    logic [ADDR_W-1:0]  rd_addr;
    logic [BYTES_W-1:0] rd_bytes;
    logic               rd_done;

    logic               wr_valid;
    logic               wr_ready;
    logic [ADDR_W-1:0]  wr_addr;
    logic [BYTES_W-1:0] wr_bytes;
    logic               wr_done;

    modport master (
        output rd_valid, rd_addr, rd_bytes, wr_valid, wr_addr, wr_bytes,
        input  rd_ready, rd_done, wr_ready, wr_done
    );

    modport slave (
        input  rd_valid, rd_addr, rd_bytes, wr_valid, wr_addr, wr_bytes,
        output rd_ready, rd_done, wr_ready, wr_done
    );
endinterface

// File: rtl/dma_desc_sched.sv
// DMA descriptor scheduler: round-robin descriptor pick, paired rd/wr job issue, completion
// tracking, abort and drain. Optional WAIT watchdog is built when DMA_SCHED_TIMEOUT_EN is defined.
`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 4
`endif

module dma_desc_sched #(
    parameter int unsigned NUM_DESC    = `DMA_NUM_DESC,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BYTES_W     = 32,
    parameter int unsigned TIMEOUT_CYC = 4096,
    localparam int unsigned PTR_W      = $clog2(NUM_DESC)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        go_i,
    input  logic                        abort_i,
    input  logic [NUM_DESC-1:0]         desc_en_i,
    input  logic [NUM_DESC*ADDR_W-1:0]  desc_src_i,
    input  logic [NUM_DESC*ADDR_W-1:0]  desc_dst_i,
    input  logic [NUM_DESC*BYTES_W-1:0] desc_bytes_i,
    dma_desc_sched_if.master            strm,
    input  logic                        pend_txn_i,
    output logic                        clear_o,
    output logic                        active_o,
    output logic                        done_o,
    output logic [PTR_W-1:0]            cur_desc_o,
    output logic [NUM_DESC-1:0]         desc_done_o,
    output logic                        err_tmo_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [NUM_DESC-1:0] pend_mask_q, pend_mask_d;
    logic [NUM_DESC-1:0] desc_done_q, desc_done_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    cur_q, cur_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [BYTES_W-1:0]  bytes_q, bytes_d;
    logic                rd_acc_q, rd_acc_d;
    logic                wr_acc_q, wr_acc_d;
    logic                rd_fin_q, rd_fin_d;
    logic                wr_fin_q, wr_fin_d;
    logic                forced_q, forced_d;
    logic                start_clear, drain_clear;

`ifdef DMA_SCHED_TIMEOUT_EN
    logic [15:0]         tmo_cnt_q, tmo_cnt_d;
    logic                err_tmo_q, err_tmo_d;
`endif

    logic [ADDR_W-1:0]   src_arr   [NUM_DESC];
    logic [ADDR_W-1:0]   dst_arr   [NUM_DESC];
    logic [BYTES_W-1:0]  bytes_arr [NUM_DESC];

    for (genvar k = 0; k < NUM_DESC; k++) begin : g_unpack
        assign src_arr[k]   = desc_src_i[k*ADDR_W +: ADDR_W];
        assign dst_arr[k]   = desc_dst_i[k*ADDR_W +: ADDR_W];
        assign bytes_arr[k] = desc_bytes_i[k*BYTES_W +: BYTES_W];
    end

    // Circular scan of the pending mask starting at the round-robin pointer.
    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] cand;
    int unsigned      idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        idx        = 0;
        for (int unsigned i = 0; i < NUM_DESC; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_DESC) begin
                idx = idx - NUM_DESC;
            end
            cand = PTR_W'(idx);
            if (!pick_found && pend_mask_q[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_mask_d = pend_mask_q;
        desc_done_d = desc_done_q;
        rr_ptr_d    = rr_ptr_q;
        cur_d       = cur_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        bytes_d     = bytes_q;
        rd_acc_d    = rd_acc_q;
        wr_acc_d    = wr_acc_q;
        rd_fin_d    = rd_fin_q;
        wr_fin_d    = wr_fin_q;
        forced_d    = forced_q;
        start_clear = 1'b0;
        drain_clear = 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        err_tmo_d   = err_tmo_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (go_i && !abort_i) begin
                    state_d     = ST_SELECT;
                    pend_mask_d = desc_en_i;
                    desc_done_d = '0;
                    forced_d    = 1'b0;
                    start_clear = 1'b1;
`ifdef DMA_SCHED_TIMEOUT_EN
                    err_tmo_d   = 1'b0;
`endif
                end
            end

            ST_SELECT: begin
                if (abort_i) begin
                    state_d     = ST_DRAIN;
                    pend_mask_d = '0;
                    forced_d    = 1'b1;
                end else if (!pick_found) begin
                    state_d = ST_DRAIN;
                end else if (bytes_arr[pick_idx] == '0) begin
                    // Zero-length slots complete without touching the streamers.
                    pend_mask_d[pick_idx] = 1'b0;
                    desc_done_d[pick_idx] = 1'b1;
                end else begin
                    state_d   = ST_ISSUE;
                    cur_d     = pick_idx;
                    rd_addr_d = src_arr[pick_idx];
                    wr_addr_d = dst_arr[pick_idx];
                    bytes_d   = bytes_arr[pick_idx];
                    rd_acc_d  = 1'b0;
                    wr_acc_d  = 1'b0;
                end
            end

            ST_ISSUE: begin
                if (abort_i) begin
                    state_d     = ST_DRAIN;
                    pend_mask_d = '0;
                    forced_d    = 1'b1;
                end else begin
                    rd_acc_d = rd_acc_q | strm.rd_ready;
                    wr_acc_d = wr_acc_q | strm.wr_ready;
                    if (rd_acc_d && wr_acc_d) begin
                        state_d  = ST_WAIT;
                        rd_fin_d = 1'b0;
                        wr_fin_d = 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
                        tmo_cnt_d = '0;
`endif
                    end
                end
            end

            ST_WAIT: begin
                rd_fin_d = rd_fin_q | strm.rd_done;
                wr_fin_d = wr_fin_q | strm.wr_done;
                if (abort_i) begin
                    state_d     = ST_DRAIN;
                    pend_mask_d = '0;
                    forced_d    = 1'b1;
`ifdef DMA_SCHED_TIMEOUT_EN
                end else if (tmo_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                    state_d     = ST_DRAIN;
                    pend_mask_d = '0;
                    forced_d    = 1'b1;
                    err_tmo_d   = 1'b1;
`endif
                end else if (rd_fin_d && wr_fin_d) begin
                    state_d            = ST_SELECT;
                    desc_done_d[cur_q] = 1'b1;
                    pend_mask_d[cur_q] = 1'b0;
                    rr_ptr_d = (cur_q == PTR_W'(NUM_DESC - 1)) ? '0 : cur_q + 1'b1;
                end
`ifdef DMA_SCHED_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
            end

            ST_DRAIN: begin
                if (!pend_txn_i) begin
                    state_d     = ST_DONE;
                    drain_clear = forced_q;
                end
            end

            ST_DONE: begin
                if (!go_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_mask_q <= '0;
            desc_done_q <= '0;
            rr_ptr_q    <= '0;
            cur_q       <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            bytes_q     <= '0;
            rd_acc_q    <= 1'b0;
            wr_acc_q    <= 1'b0;
            rd_fin_q    <= 1'b0;
            wr_fin_q    <= 1'b0;
            forced_q    <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            err_tmo_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pend_mask_q <= pend_mask_d;
            desc_done_q <= desc_done_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_q       <= cur_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            bytes_q     <= bytes_d;
            rd_acc_q    <= rd_acc_d;
            wr_acc_q    <= wr_acc_d;
            rd_fin_q    <= rd_fin_d;
            wr_fin_q    <= wr_fin_d;
            forced_q    <= forced_d;
`ifdef DMA_SCHED_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            err_tmo_q   <= err_tmo_d;
`endif
        end
    end

    assign strm.rd_valid = (state_q == ST_ISSUE) && !rd_acc_q;
    assign strm.wr_valid = (state_q == ST_ISSUE) && !wr_acc_q;
    assign strm.rd_addr  = rd_addr_q;
    assign strm.wr_addr  = wr_addr_q;
    assign strm.rd_bytes = bytes_q;
    assign strm.wr_bytes = bytes_q;

    // Gated by rst so a start request held through reset cannot pulse the clear.
    assign clear_o     = !rst && (start_clear || drain_clear);
    assign active_o    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o      = (state_q == ST_DONE);
    assign cur_desc_o  = cur_q;
    assign desc_done_o = desc_done_q;

`ifdef DMA_SCHED_TIMEOUT_EN
    assign err_tmo_o = err_tmo_q;
`else
    logic unused_tmo_cyc;
    assign unused_tmo_cyc = ^TIMEOUT_CYC;
    assign err_tmo_o      = 1'b0;
`endif

endmodule

// File: tb/tb_dma_desc_sched.sv
// Scoreboard bench for dma_desc_sched: a reference model predicts issued jobs and completion
// masks per run; a negedge monitor pops and compares on every streamer handshake.
module tb_dma_desc_sched;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned BW = 32;

    typedef struct {
        int unsigned slot;
        logic [31:0] addr;
        logic [31:0] bytes;
    } job_t;

    logic            clk = 1'b0;
    logic            rst, go_i, abort_i, pend_txn_i;
    logic [N-1:0]    desc_en_i;
    logic [N*AW-1:0] desc_src_i, desc_dst_i;
    logic [N*BW-1:0] desc_bytes_i;
    logic            clear_o, active_o, done_o, err_tmo_o;
    logic [1:0]      cur_desc_o;
    logic [N-1:0]    desc_done_o;

    dma_desc_sched_if #(.ADDR_W(AW), .BYTES_W(BW)) strm ();

    dma_desc_sched #(.NUM_DESC(N), .ADDR_W(AW), .BYTES_W(BW), .TIMEOUT_CYC(4096)) dut (
        .clk          (clk),
        .rst          (rst),
        .go_i         (go_i),
        .abort_i      (abort_i),
        .desc_en_i    (desc_en_i),
        .desc_src_i   (desc_src_i),
        .desc_dst_i   (desc_dst_i),
        .desc_bytes_i (desc_bytes_i),
        .strm         (strm),
        .pend_txn_i   (pend_txn_i),
        .clear_o      (clear_o),
        .active_o     (active_o),
        .done_o       (done_o),
        .cur_desc_o   (cur_desc_o),
        .desc_done_o  (desc_done_o),
        .err_tmo_o    (err_tmo_o)
    );

    always #5 clk = ~clk;

    job_t        exp_rd_q[$], exp_wr_q[$];
    int unsigned rd_len_q[$], wr_len_q[$];
    int unsigned vectors = 0, miscompares = 0, clear_cnt = 0;
    int unsigned model_rr = 0;
    int unsigned rd_run = 0, wr_run = 0;
    bit          hold_done = 1'b0;
    job_t        mj;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a handshake is visible at the negedge before the accepting edge.
    always @(negedge clk) begin
        if (clear_o === 1'b1) clear_cnt++;
        if (strm.rd_valid === 1'b1) begin
            rd_run++;
            if (strm.rd_ready === 1'b1) begin
                check("rd_job_expected", 64'(exp_rd_q.size() > 0), 64'd1);
                if (exp_rd_q.size() > 0) begin
                    mj = exp_rd_q.pop_front();
                    check("rd_payload", {strm.rd_addr, strm.rd_bytes}, {mj.addr, mj.bytes});
                    check("rd_slot", 64'(cur_desc_o), 64'(mj.slot));
                end
                if (rd_len_q.size() > 0) check("rd_valid_len", 64'(rd_run), 64'(rd_len_q.pop_front()));
                rd_run = 0;
            end
        end else begin
            rd_run = 0;
        end
        if (strm.wr_valid === 1'b1) begin
            wr_run++;
            if (strm.wr_ready === 1'b1) begin
                check("wr_job_expected", 64'(exp_wr_q.size() > 0), 64'd1);
                if (exp_wr_q.size() > 0) begin
                    mj = exp_wr_q.pop_front();
                    check("wr_payload", {strm.wr_addr, strm.wr_bytes}, {mj.addr, mj.bytes});
                    check("wr_slot", 64'(cur_desc_o), 64'(mj.slot));
                end
                if (wr_len_q.size() > 0) check("wr_valid_len", 64'(wr_run), 64'(wr_len_q.pop_front()));
                wr_run = 0;
            end
        end else begin
            wr_run = 0;
        end
    end

    // Streamer model: random accept latency, done pulse some cycles after both jobs are taken.
    task automatic responder(input bit is_rd);
        int unsigned lat, n;
        forever begin
            @(posedge clk); #1;
            if ((is_rd ? strm.rd_valid : strm.wr_valid) === 1'b1) begin
                lat = $urandom_range(0, 3);
                if (is_rd) rd_len_q.push_back(lat + 1);
                else       wr_len_q.push_back(lat + 1);
                repeat (lat) @(posedge clk);
                #1;
                if (is_rd) strm.rd_ready = 1'b1;
                else       strm.wr_ready = 1'b1;
                @(posedge clk); #1;
                if (is_rd) strm.rd_ready = 1'b0;
                else       strm.wr_ready = 1'b0;
                if (!hold_done) begin
                    n = 0;
                    while ((strm.rd_valid || strm.wr_valid) && n < 20) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    lat = $urandom_range(0, 4);
                    repeat (lat) @(posedge clk);
                    #1;
                    if (is_rd) strm.rd_done = 1'b1;
                    else       strm.wr_done = 1'b1;
                    @(posedge clk); #1;
                    if (is_rd) strm.rd_done = 1'b0;
                    else       strm.wr_done = 1'b0;
                end
            end
        end
    endtask

    initial responder(1'b1);
    initial responder(1'b0);

    task automatic wait_jobs_taken();
        int unsigned n = 0;
        while ((exp_rd_q.size() + exp_wr_q.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("jobs_taken", 64'(exp_rd_q.size() + exp_wr_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [N-1:0] en, input logic [N*BW-1:0] bytes,
                       input bit abort_run, input bit drop_go);
        int unsigned k, p, n, n0, bad;
        logic [N-1:0] exp_done;
        bit stop;
        job_t j;
        desc_en_i    = en;
        desc_bytes_i = bytes;
        for (int i = 0; i < N; i++) begin
            desc_src_i[i*AW +: AW] = $urandom;
            desc_dst_i[i*AW +: AW] = $urandom;
        end
        hold_done = abort_run;
        // One circular pass from the round-robin pointer over the enabled slots.
        exp_done = '0;
        stop     = 1'b0;
        p        = model_rr;
        for (int i = 0; i < N; i++) begin
            k = (model_rr + i) % N;
            if (en[k] && !stop) begin
                exp_done[k] = 1'b1;
                if (bytes[k*BW +: BW] != 0) begin
                    j.slot  = k;
                    j.bytes = bytes[k*BW +: BW];
                    j.addr  = desc_src_i[k*AW +: AW];
                    exp_rd_q.push_back(j);
                    j.addr  = desc_dst_i[k*AW +: AW];
                    exp_wr_q.push_back(j);
                    p = (k + 1) % N;
                    if (abort_run) begin
                        exp_done[k] = 1'b0;
                        stop        = 1'b1;
                    end
                end
            end
        end
        if (!abort_run) model_rr = p;

        n0 = clear_cnt;
        @(posedge clk); #1 go_i = 1'b1;
        @(negedge clk);
        check("start_clear", 64'(clear_o), 64'd1);
        if (drop_go) begin
            @(posedge clk); #1 go_i = 1'b0;
        end
        if (abort_run) begin
            wait_jobs_taken();
            abort_i    = 1'b1;
            pend_txn_i = 1'b1;
            @(posedge clk); #1 abort_i = 1'b0;
            bad = 0;
            repeat (9) begin
                @(negedge clk);
                if (!(active_o === 1'b1 && done_o === 1'b0 && clear_o === 1'b0)) bad++;
                @(posedge clk);
            end
            check("drain_hold", 64'(bad), 64'd0);
            #1 pend_txn_i = 1'b0;
            @(negedge clk);
            check("drain_exit_clear", {62'd0, clear_o, active_o}, 64'd3);
        end
        n = 0;
        while (done_o !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("run_done", 64'(done_o), 64'd1);
        check("desc_done", 64'(desc_done_o), 64'(exp_done));
        check("err_tmo", 64'(err_tmo_o), 64'd0);
        check("clear_count", 64'(clear_cnt - n0), abort_run ? 64'd2 : 64'd1);
        check("queues_drained", 64'(exp_rd_q.size() + exp_wr_q.size()), 64'd0);
        @(posedge clk); #1 go_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("back_to_idle", {62'd0, active_o, done_o}, 64'd0);
    endtask

    initial begin
        logic [N-1:0]    en;
        logic [N*BW-1:0] by;
        bit              ab;
        int unsigned     n0;
        rst          = 1'b1;
        go_i         = 1'b0;
        abort_i      = 1'b0;
        pend_txn_i   = 1'b0;
        desc_en_i    = '0;
        desc_src_i   = '0;
        desc_dst_i   = '0;
        desc_bytes_i = '0;
        strm.rd_ready = 1'b0;
        strm.wr_ready = 1'b0;
        strm.rd_done  = 1'b0;
        strm.wr_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_status", {52'd0, clear_o, active_o, done_o, cur_desc_o, desc_done_o, err_tmo_o,
                               strm.rd_valid, strm.wr_valid}, 64'd0);
        check("reset_payload", {strm.rd_addr, strm.wr_addr}, 64'd0);

        run(4'b0011, {32'd0, 32'd0, 32'd32, 32'd64}, 1'b0, 1'b0);
        run(4'b0011, {32'd0, 32'd0, 32'd32, 32'd0}, 1'b0, 1'b0);
        run(4'b0011, {32'd0, 32'd0, 32'd32, 32'd64}, 1'b1, 1'b0);
        run(4'b0000, {32'd9, 32'd9, 32'd9, 32'd9}, 1'b0, 1'b0);
        run(4'b1111, {32'd4, 32'd0, 32'd7, 32'd1}, 1'b0, 1'b1);

        for (int r = 0; r < 24; r++) begin
            en = N'($urandom);
            for (int i = 0; i < N; i++) begin
                by[i*BW +: BW] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
            end
            ab = ($urandom_range(0, 4) == 0);
            if (ab) begin
                en[0]       = 1'b1;
                by[0 +: BW] = 32'd128;
            end
            run(en, by, ab, $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of a job.
        hold_done    = 1'b1;
        desc_en_i    = 4'b1111;
        desc_bytes_i = {32'd5, 32'd6, 32'd7, 32'd8};
        mj.slot  = model_rr;
        mj.bytes = desc_bytes_i[model_rr*BW +: BW];
        mj.addr  = desc_src_i[model_rr*AW +: AW];
        exp_rd_q.push_back(mj);
        mj.addr  = desc_dst_i[model_rr*AW +: AW];
        exp_wr_q.push_back(mj);
        @(posedge clk); #1 go_i = 1'b1;
        wait_jobs_taken();
        n0  = clear_cnt;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrun_reset", {51'd0, clear_o, active_o, done_o, cur_desc_o, desc_done_o, err_tmo_o,
                               strm.rd_valid, strm.wr_valid, 1'b0}, 64'd0);
        check("midrun_reset_no_clear", 64'(clear_cnt - n0), 64'd0);
        go_i = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        model_rr = 0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end
endmodule
